// File: rtl/sound_pkg.sv
// Shared types and constants for the sound arbiter: state encoding, mode codes, music sections.
// The GAP state exists only when SOUND_ARB_GAP_EN is defined.
package sound_pkg;

  localparam int ADDR_W = 11;
  localparam int FREQ_W = 16;
  localparam int OFF_W  = 8;

  typedef enum logic [1:0] {
    MODE_HOME  = 2'd0,
    MODE_NAME  = 2'd1,
    MODE_GAME0 = 2'd2,
    MODE_GAME1 = 2'd3
  } mode_e;

`ifdef SOUND_ARB_GAP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BGM  = 2'd1,
    ST_SFX  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BGM  = 2'd1,
    ST_SFX  = 2'd2
  } state_e;
`endif

  // Inclusive ROM address bounds of each background-music section
  localparam logic [ADDR_W-1:0] HOME_START = 11'd552;
  localparam logic [ADDR_W-1:0] HOME_END   = 11'd1111;
  localparam logic [ADDR_W-1:0] NAME_START = 11'd1112;
  localparam logic [ADDR_W-1:0] NAME_END   = 11'd1728;
  localparam logic [ADDR_W-1:0] GAME_START = 11'd0;
  localparam logic [ADDR_W-1:0] GAME_END   = 11'd552;

  function automatic logic [ADDR_W-1:0] sfx_entry(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] len,
                                                  input logic [1:0]        id);
    logic [ADDR_W-1:0] id_w;
    id_w = {{(ADDR_W-2){1'b0}}, id};
    return base + len * id_w;
  endfunction

endpackage

// File: rtl/section_sel.sv
// Combinational lookup from operating mode to the start/end ROM addresses of its music section.
module section_sel
  import sound_pkg::*;
(
  input  logic [1:0]        mode_i,
  output logic [ADDR_W-1:0] start_o,
  output logic [ADDR_W-1:0] end_o
);

  always_comb begin
    start_o = GAME_START;
    end_o   = GAME_END;
    case (mode_i)
      MODE_HOME: begin
        start_o = HOME_START;
        end_o   = HOME_END;
      end
      MODE_NAME: begin
        start_o = NAME_START;
        end_o   = NAME_END;
      end
      default: begin
        start_o = GAME_START;
        end_o   = GAME_END;
      end
    endcase
  end

endmodule

// File: rtl/sound_arbiter.sv
// Shares one tone ROM between background music and sound effects; a request interrupts music,
// plays SFX_LEN entries, then resumes. Optional SOUND_ARB_GAP_EN inserts a one-tick silent GAP.
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int unsigned SFX_BASE = 1792,
  parameter int unsigned SFX_LEN  = 64
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              tick,
  input  logic [1:0]        mode,
  input  logic              sfx_req,
  input  logic [1:0]        sfx_id,
  input  logic [FREQ_W-1:0] rom_freq,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [FREQ_W-1:0] freq,
  output logic              sfx_ack,
  output logic              sfx_busy
);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(SFX_BASE);
  localparam logic [ADDR_W-1:0] LEN_A    = ADDR_W'(SFX_LEN);
  localparam logic [OFF_W-1:0]  LAST_OFF = OFF_W'(SFX_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] save_q, save_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [1:0]        mode_q;
  logic              valid_q, valid_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              reload;
  logic              mode_chg;
  logic              in_gap;
  logic [ADDR_W-1:0] sec_start;
  logic [ADDR_W-1:0] sec_end;

  section_sel u_section_sel (
    .mode_i  (mode),
    .start_o (sec_start),
    .end_o   (sec_end)
  );

  assign mode_chg = (mode != mode_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    save_d  = save_q;
    off_d   = off_q;
    ack_d   = 1'b0;
    reload  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_BGM;
        addr_d  = sec_start;
        reload  = 1'b1;
      end
      ST_BGM: begin
        // Mode change beats a request; a held request is taken on the following cycle
        if (mode_chg) begin
          addr_d = sec_start;
          reload = 1'b1;
        end else if (sfx_req) begin
          save_d  = addr_q;
          addr_d  = sfx_entry(BASE_A, LEN_A, sfx_id);
          off_d   = '0;
          ack_d   = 1'b1;
          reload  = 1'b1;
          state_d = ST_SFX;
        end else if (tick) begin
          if (addr_q == sec_end) begin
            addr_d = sec_start;
            reload = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_SFX: begin
        if (mode_chg) begin
          save_d = sec_start;
        end
        if (tick) begin
          if (off_q == LAST_OFF) begin
            addr_d = save_d;
            reload = 1'b1;
`ifdef SOUND_ARB_GAP_EN
            state_d = ST_GAP;
`else
            state_d = ST_BGM;
`endif
          end else begin
            addr_d = addr_q + 1'b1;
            off_d  = off_q + 1'b1;
          end
        end
      end
`ifdef SOUND_ARB_GAP_EN
      ST_GAP: begin
        if (mode_chg) begin
          addr_d = sec_start;
          reload = 1'b1;
        end
        if (tick) begin
          state_d = ST_BGM;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    valid_d = ~reload;
`ifdef SOUND_ARB_GAP_EN
    busy_d  = (state_d == ST_SFX) || (state_d == ST_GAP);
`else
    busy_d  = (state_d == ST_SFX);
`endif
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      save_q  <= '0;
      off_q   <= '0;
      mode_q  <= MODE_HOME;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      save_q  <= save_d;
      off_q   <= off_d;
      mode_q  <= mode;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SOUND_ARB_GAP_EN
  assign in_gap = (state_q == ST_GAP);
`else
  assign in_gap = 1'b0;
`endif

  // ROM data lags the address by a cycle, so a jump leaves one cycle of stale data to mute
  assign freq     = (valid_q && !in_gap) ? rom_freq : '0;
  assign rom_addr = addr_q;
  assign sfx_ack  = ack_q;
  assign sfx_busy = busy_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Scoreboard bench for sound_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_sound_arbiter;

  localparam int SFX_BASE = 1792;
  localparam int SFX_LEN  = 64;
`ifdef SOUND_ARB_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [10:0] addr;
    logic [15:0] freq;
    logic        ack;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        tick = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        sfx_req = 1'b0;
  logic [1:0]  sfx_id = 2'd0;
  logic [15:0] rom_freq;
  logic [10:0] rom_addr;
  logic [15:0] freq;
  logic        sfx_ack;
  logic        sfx_busy;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  sound_arbiter #(.SFX_BASE(SFX_BASE), .SFX_LEN(SFX_LEN)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .tick     (tick),
    .mode     (mode),
    .sfx_req  (sfx_req),
    .sfx_id   (sfx_id),
    .rom_freq (rom_freq),
    .rom_addr (rom_addr),
    .freq     (freq),
    .sfx_ack  (sfx_ack),
    .sfx_busy (sfx_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_val(input int a);
    return 16'hA000 | 16'(a);
  endfunction

  assign rom_freq = rom_val(int'(rom_addr));

  function automatic int sec_start(input logic [1:0] m);
    if (m == 2'd0) return 552;
    if (m == 2'd1) return 1112;
    return 0;
  endfunction

  function automatic int sec_end(input logic [1:0] m);
    if (m == 2'd0) return 1111;
    if (m == 2'd1) return 1728;
    return 552;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Behavioural reference: music position, effect progress and resume point as plain integers
  initial begin : model
    bit         started, sfx_on, gap_on, m_valid, ack_e;
    int         pos, resume_a, played, eid, addr_e;
    logic [1:0] prev_m;
    exp_t       e;
    started = 0; sfx_on = 0; gap_on = 0; m_valid = 0;
    pos = 0; resume_a = 0; played = 0; eid = 0; prev_m = 2'd0;
    forever begin
      @(posedge clk or negedge clrn);
      if (!clrn) begin
        started = 0; sfx_on = 0; gap_on = 0; m_valid = 0;
        exp_q.delete();
      end else begin
        ack_e = 0;
        if (!started) begin
          started = 1;
          pos = sec_start(mode);
          m_valid = 0;
        end else if (sfx_on) begin
          m_valid = 1;
          if (mode != prev_m) resume_a = sec_start(mode);
          if (tick) begin
            played++;
            if (played == SFX_LEN) begin
              sfx_on = 0;
              pos = resume_a;
              m_valid = 0;
              gap_on = GAP_EN;
            end
          end
        end else if (gap_on) begin
          m_valid = 1;
          if (mode != prev_m) begin
            pos = sec_start(mode);
            m_valid = 0;
          end
          if (tick) gap_on = 0;
        end else begin
          m_valid = 1;
          if (mode != prev_m) begin
            pos = sec_start(mode);
            m_valid = 0;
          end else if (sfx_req) begin
            resume_a = pos;
            sfx_on = 1;
            played = 0;
            eid = int'(sfx_id);
            ack_e = 1;
            m_valid = 0;
          end else if (tick) begin
            if (pos == sec_end(mode)) begin
              pos = sec_start(mode);
              m_valid = 0;
            end else begin
              pos++;
            end
          end
        end
        prev_m = mode;
        addr_e = sfx_on ? (SFX_BASE + eid * SFX_LEN + played) : pos;
        e.addr = 11'(addr_e);
        e.freq = (m_valid && !gap_on) ? rom_val(addr_e) : 16'd0;
        e.ack  = ack_e;
        e.busy = sfx_on || gap_on;
        exp_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!clrn) begin
        chk("reset_addr", 32'(rom_addr), 0);
        chk("reset_freq", 32'(freq), 0);
        chk("reset_ack", 32'(sfx_ack), 0);
        chk("reset_busy", 32'(sfx_busy), 0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_addr", 32'(rom_addr), 32'(e.addr));
        chk("sb_freq", 32'(freq), 32'(e.freq));
        chk("sb_ack", 32'(sfx_ack), 32'(e.ack));
        chk("sb_busy", 32'(sfx_busy), 32'(e.busy));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (!sfx_busy) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk(nm, 32'(ok), 1);
  endtask

  initial begin : stim
    bit found;
    repeat (3) @(negedge clk);
    #2 clrn = 1'b1;
    @(negedge clk);
    chk("release_addr", 32'(rom_addr), 552);
    chk("release_freq", 32'(freq), 0);

    // Home section wrap
    tick = 1'b1;
    repeat (559) @(negedge clk);
    chk("home_end", 32'(rom_addr), 1111);
    @(negedge clk);
    chk("home_wrap", 32'(rom_addr), 552);
    chk("wrap_mute", 32'(freq), 0);
    repeat (148) @(negedge clk);
    chk("home_700", 32'(rom_addr), 700);

    // Mode change to in-game
    tick = 1'b0;
    mode = 2'd2;
    @(negedge clk);
    chk("mode_load", 32'(rom_addr), 0);
    chk("mode_mute", 32'(freq), 0);
    @(negedge clk);
    chk("mode_unmute", 32'(freq), 32'(16'hA000));

    // Effect 2 from address 20, with a second request ignored mid-effect
    tick = 1'b1;
    repeat (20) @(negedge clk);
    chk("game_20", 32'(rom_addr), 20);
    tick = 1'b0;
    sfx_req = 1'b1;
    sfx_id = 2'd2;
    @(negedge clk);
    chk("sfx2_ack", 32'(sfx_ack), 1);
    chk("sfx2_addr", 32'(rom_addr), 1920);
    chk("sfx2_busy", 32'(sfx_busy), 1);
    sfx_req = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) begin
        sfx_req = 1'b1;
        sfx_id = 2'd0;
      end
      if (i == 13) sfx_req = 1'b0;
      @(negedge clk);
      if (i == 11) begin
        chk("second_req_ack", 32'(sfx_ack), 0);
        chk("second_req_addr", 32'(rom_addr), 1932);
      end
    end
    chk("sfx2_resume", 32'(rom_addr), 20);

    // Tick and request together at 30
    tick = 1'b0;
    wait_idle("idle_after_sfx2");
    tick = 1'b1;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (rom_addr == 11'd30) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_30", 32'(found), 1);
    sfx_req = 1'b1;
    sfx_id = 2'd1;
    @(negedge clk);
    chk("sfx1_ack", 32'(sfx_ack), 1);
    chk("sfx1_addr", 32'(rom_addr), 1856);
    sfx_req = 1'b0;
    repeat (64) @(negedge clk);
    chk("sfx1_resume", 32'(rom_addr), 30);

    // Reset in the middle of an effect
    tick = 1'b0;
    wait_idle("idle_after_sfx1");
    sfx_req = 1'b1;
    sfx_id = 2'd3;
    @(negedge clk);
    chk("sfx3_ack", 32'(sfx_ack), 1);
    sfx_req = 1'b0;
    tick = 1'b1;
    repeat (5) @(negedge clk);
    chk("sfx3_busy", 32'(sfx_busy), 1);
    #2 clrn = 1'b0;
    mode = 2'd1;
    #1;
    chk("async_addr", 32'(rom_addr), 0);
    chk("async_freq", 32'(freq), 0);
    chk("async_busy", 32'(sfx_busy), 0);
    chk("async_ack", 32'(sfx_ack), 0);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    #2 clrn = 1'b1;
    @(negedge clk);
    chk("restart_addr", 32'(rom_addr), 1112);
    chk("restart_busy", 32'(sfx_busy), 0);
    tick = 1'b1;
    @(negedge clk);
    chk("restart_step", 32'(rom_addr), 1113);

    // Random traffic
    for (int n = 0; n < 2500; n++) begin
      tick = ($urandom_range(0, 2) == 0);
      sfx_req = ($urandom_range(0, 39) == 0);
      sfx_id = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    tick = 1'b0;
    sfx_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
